// File: rtl/adv_ddr_rx_pkg.sv
// Shared definitions for the ADV7511-style DDR video path: lock FSM encoding,
// default measurement widths and a small saturating-increment helper.
package adv_ddr_rx_pkg;

   typedef enum logic [1:0] {
      StUnlocked = 2'd0,
      StCheck    = 2'd1,
      StLocked   = 2'd2
   } lock_state_e;

   localparam int unsigned DefHW = 12;
   localparam int unsigned DefVW = 11;

   function automatic logic [7:0] sat_inc8(input logic [7:0] val);
      return (val == 8'hFF) ? val : val + 8'd1;
   endfunction

endpackage

// File: rtl/adv_ddr_rx_measure.sv
// Active-area measurement: pixels per line, lines per frame, line-consistency
// flag, and the geometry latched at each vsync edge once a full frame was seen.
module adv_ddr_rx_measure
   import adv_ddr_rx_pkg::*;
#(
   parameter int unsigned H_W = DefHW,
   parameter int unsigned V_W = DefVW
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           pix_valid_i,
   input  logic           de_i,
   input  logic           vs_edge_i,
   output logic           frame_edge_o,
   output logic [H_W-1:0] meas_h_o,
   output logic [V_W-1:0] meas_v_o,
   output logic           frame_bad_o,
   output logic [H_W-1:0] h_active_o,
   output logic [V_W-1:0] v_active_o
);

   logic [H_W-1:0] h_cnt_q, h_cnt_d, first_w_q, first_w_d, h_active_q, h_active_d;
   logic [V_W-1:0] v_cnt_q, v_cnt_d, v_active_q, v_active_d;
   logic           de_prev_q, de_prev_d, frame_bad_q, frame_bad_d, started_q, started_d;
   logic           de_fall;

   always_comb begin
      h_cnt_d     = h_cnt_q;
      first_w_d   = first_w_q;
      h_active_d  = h_active_q;
      v_cnt_d     = v_cnt_q;
      v_active_d  = v_active_q;
      frame_bad_d = frame_bad_q;
      started_d   = started_q;
      de_prev_d   = de_i;
      de_fall     = de_prev_q & ~de_i;

      if (pix_valid_i && h_cnt_q != '1) h_cnt_d = h_cnt_q + H_W'(1);
      if (de_fall) begin
         h_cnt_d = '0;
         if (v_cnt_q == '0) first_w_d = h_cnt_q;
         else if (h_cnt_q != first_w_q) frame_bad_d = 1'b1;
         if (v_cnt_q != '1) v_cnt_d = v_cnt_q + V_W'(1);
      end

      // Nothing is accumulated until a vsync edge has marked a frame start.
      if (!started_q) begin
         h_cnt_d     = '0;
         v_cnt_d     = '0;
         first_w_d   = '0;
         frame_bad_d = 1'b0;
      end

      if (vs_edge_i) begin
         if (started_q) begin
            h_active_d = first_w_q;
            v_active_d = v_cnt_q;
         end
         started_d   = 1'b1;
         h_cnt_d     = '0;
         v_cnt_d     = '0;
         first_w_d   = '0;
         frame_bad_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         h_cnt_q     <= '0;
         first_w_q   <= '0;
         h_active_q  <= '0;
         v_cnt_q     <= '0;
         v_active_q  <= '0;
         de_prev_q   <= 1'b0;
         frame_bad_q <= 1'b0;
         started_q   <= 1'b0;
      end else begin
         h_cnt_q     <= h_cnt_d;
         first_w_q   <= first_w_d;
         h_active_q  <= h_active_d;
         v_cnt_q     <= v_cnt_d;
         v_active_q  <= v_active_d;
         de_prev_q   <= de_prev_d;
         frame_bad_q <= frame_bad_d;
         started_q   <= started_d;
      end
   end

   assign frame_edge_o = vs_edge_i & started_q;
   assign meas_h_o     = first_w_q;
   assign meas_v_o     = v_cnt_q;
   assign frame_bad_o  = frame_bad_q;
   assign h_active_o   = h_active_q;
   assign v_active_o   = v_active_q;

endmodule

// File: rtl/adv_ddr_rx.sv
// DDR video receiver: double-registers the 12-bit DDR bus, pairs half-words into
// 24-bpp pixels, checks the forwarded clock phase and tracks frame-geometry lock.
module adv_ddr_rx
   import adv_ddr_rx_pkg::*;
#(
   parameter int unsigned LOCK_FRAMES = 3,
   parameter int unsigned H_W         = DefHW,
   parameter int unsigned V_W         = DefVW
) (
   input  logic           clk_in,
   input  logic           reset,
   input  logic           clk_pixel,
   input  logic           de_in,
   input  logic           hsync,
   input  logic           vsync,
   input  logic [11:0]    data,
   output logic [23:0]    pixel_out,
   output logic           pixel_valid,
   output logic           de_out,
   output logic           hsync_out,
   output logic           vsync_out,
   output logic [H_W-1:0] h_active,
   output logic [V_W-1:0] v_active,
   output logic           locked,
   output logic           phase_err,
   output logic [7:0]     err_count
);

   localparam int unsigned CntW = $clog2(LOCK_FRAMES + 1);

   // Input word layout: {clk_pixel, de, hsync, vsync, data[11:0]}.
   logic [15:0] in_s1_q, in_s1_d, in_s2_q, in_s2_d;
   logic [2:0]  vld_q, vld_d;
   logic        clk_prev_q, clk_prev_d, vs_prev_q, vs_prev_d;
   logic        have_low_q, have_low_d, de_lo_q, de_lo_d;
   logic [11:0] low_q, low_d;
   logic [23:0] pixel_q, pixel_d;
   logic        pix_valid_q, pix_valid_d, de_out_q, de_out_d, hs_out_q, hs_out_d;
   logic        vs_out_q, vs_out_d, phase_err_q, phase_err_d;
   logic        s2_clk, phase_hit, vs_edge;

   lock_state_e    state_q, state_d;
   logic [H_W-1:0] ref_h_q, ref_h_d, meas_h;
   logic [V_W-1:0] ref_v_q, ref_v_d, meas_v;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [7:0]     err_q, err_d;
   logic           locked_q, locked_d, frame_edge, frame_bad, geom_ok;

   assign s2_clk    = in_s2_q[15];
   // vld_q[1]: s2 holds a real sample; vld_q[2]: clk_prev_q does too.
   assign phase_hit = vld_q[1] & vld_q[2] & (s2_clk == clk_prev_q);
   assign vs_edge   = vld_q[1] & in_s2_q[12] & ~vs_prev_q;

   always_comb begin
      in_s1_d     = {clk_pixel, de_in, hsync, vsync, data};
      in_s2_d     = in_s1_q;
      vld_d       = {vld_q[1:0], 1'b1};
      clk_prev_d  = s2_clk;
      vs_prev_d   = in_s2_q[12];
      have_low_d  = have_low_q;
      low_d       = low_q;
      de_lo_d     = de_lo_q;
      pixel_d     = pixel_q;
      de_out_d    = de_out_q;
      hs_out_d    = hs_out_q;
      vs_out_d    = vs_out_q;
      pix_valid_d = 1'b0;
      phase_err_d = phase_hit;

      if (vld_q[1]) begin
         if (phase_hit) begin
            have_low_d = 1'b0;
         end else if (s2_clk) begin
            low_d      = in_s2_q[11:0];
            de_lo_d    = in_s2_q[14];
            have_low_d = 1'b1;
         end else if (have_low_q) begin
            pixel_d     = {in_s2_q[11:0], low_q};
            de_out_d    = de_lo_q;
            hs_out_d    = in_s2_q[13];
            vs_out_d    = in_s2_q[12];
            pix_valid_d = de_lo_q;
            have_low_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         in_s1_q     <= '0;
         in_s2_q     <= '0;
         vld_q       <= '0;
         clk_prev_q  <= 1'b0;
         vs_prev_q   <= 1'b0;
         have_low_q  <= 1'b0;
         low_q       <= '0;
         de_lo_q     <= 1'b0;
         pixel_q     <= '0;
         pix_valid_q <= 1'b0;
         de_out_q    <= 1'b0;
         hs_out_q    <= 1'b0;
         vs_out_q    <= 1'b0;
         phase_err_q <= 1'b0;
      end else begin
         in_s1_q     <= in_s1_d;
         in_s2_q     <= in_s2_d;
         vld_q       <= vld_d;
         clk_prev_q  <= clk_prev_d;
         vs_prev_q   <= vs_prev_d;
         have_low_q  <= have_low_d;
         low_q       <= low_d;
         de_lo_q     <= de_lo_d;
         pixel_q     <= pixel_d;
         pix_valid_q <= pix_valid_d;
         de_out_q    <= de_out_d;
         hs_out_q    <= hs_out_d;
         vs_out_q    <= vs_out_d;
         phase_err_q <= phase_err_d;
      end
   end

   adv_ddr_rx_measure #(
      .H_W(H_W),
      .V_W(V_W)
   ) u_measure (
      .clk_i       (clk_in),
      .rst_i       (reset),
      .pix_valid_i (pix_valid_q),
      .de_i        (de_out_q),
      .vs_edge_i   (vs_edge),
      .frame_edge_o(frame_edge),
      .meas_h_o    (meas_h),
      .meas_v_o    (meas_v),
      .frame_bad_o (frame_bad),
      .h_active_o  (h_active),
      .v_active_o  (v_active)
   );

   always_comb begin
      state_d = state_q;
      ref_h_d = ref_h_q;
      ref_v_d = ref_v_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      geom_ok = !frame_bad && (meas_h == ref_h_q) && (meas_v == ref_v_q);

      unique case (state_q)
         StUnlocked: begin
            if (frame_edge) begin
               ref_h_d = meas_h;
               ref_v_d = meas_v;
               cnt_d   = CntW'(1);
               state_d = (LOCK_FRAMES <= 1) ? StLocked : StCheck;
            end
         end
         StCheck: begin
            if (frame_edge) begin
               if (geom_ok) begin
                  cnt_d = cnt_q + CntW'(1);
                  if (cnt_d == CntW'(LOCK_FRAMES)) state_d = StLocked;
               end else begin
                  ref_h_d = meas_h;
                  ref_v_d = meas_v;
                  cnt_d   = CntW'(1);
               end
            end
         end
         StLocked: begin
            // A coincident phase error and bad frame count as a single loss.
            if (phase_hit || (frame_edge && !geom_ok)) begin
               state_d = StUnlocked;
               cnt_d   = '0;
               err_d   = sat_inc8(err_q);
            end
         end
         default: state_d = StUnlocked;
      endcase

      locked_d = (state_d == StLocked);
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q  <= StUnlocked;
         ref_h_q  <= '0;
         ref_v_q  <= '0;
         cnt_q    <= '0;
         err_q    <= '0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ref_h_q  <= ref_h_d;
         ref_v_q  <= ref_v_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         locked_q <= locked_d;
      end
   end

   assign pixel_out   = pixel_q;
   assign pixel_valid = pix_valid_q;
   assign de_out      = de_out_q;
   assign hsync_out   = hs_out_q;
   assign vsync_out   = vs_out_q;
   assign phase_err   = phase_err_q;
   assign locked      = locked_q;
   assign err_count   = err_q;

endmodule

// File: tb/tb_adv_ddr_rx.sv
// Self-checking bench for adv_ddr_rx: drives DDR half-word slots, scores every
// DE pixel (value and 3-cycle latency) and checks geometry, lock and error counters.
module tb_adv_ddr_rx;

   logic        clk_in    = 1'b0;
   logic        reset     = 1'b1;
   logic        clk_pixel = 1'b0;
   logic        de_in     = 1'b0;
   logic        hsync     = 1'b0;
   logic        vsync     = 1'b0;
   logic [11:0] data      = '0;
   logic [23:0] pixel_out;
   logic        pixel_valid, de_out, hsync_out, vsync_out, locked, phase_err;
   logic [11:0] h_active;
   logic [10:0] v_active;
   logic [7:0]  err_count;

   adv_ddr_rx #(
      .LOCK_FRAMES(3),
      .H_W        (12),
      .V_W        (11)
   ) dut (
      .clk_in     (clk_in),
      .reset      (reset),
      .clk_pixel  (clk_pixel),
      .de_in      (de_in),
      .hsync      (hsync),
      .vsync      (vsync),
      .data       (data),
      .pixel_out  (pixel_out),
      .pixel_valid(pixel_valid),
      .de_out     (de_out),
      .hsync_out  (hsync_out),
      .vsync_out  (vsync_out),
      .h_active   (h_active),
      .v_active   (v_active),
      .locked     (locked),
      .phase_err  (phase_err),
      .err_count  (err_count)
   );

   always #5 clk_in = ~clk_in;

   int unsigned cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   int          n_chk = 0;
   int          n_fail = 0;
   int          n_valid = 0;
   int          n_phase = 0;
   logic [23:0] exp_pix[$];
   int unsigned exp_cyc[$];

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Scoreboard consumer and strobe counters, sampled mid-cycle.
   always @(negedge clk_in) begin
      if (phase_err) n_phase++;
      if (pixel_valid && !reset) begin
         n_valid++;
         if (exp_pix.size() == 0) begin
            check_val("unexpected_pixel", 32'd1, 32'd0);
         end else begin
            check_val("pixel_out", pixel_out, exp_pix.pop_front());
            check_val("pixel_latency", cyc, exp_cyc.pop_front());
         end
      end
   end

   task automatic slot(input logic ck, input logic [11:0] d, input logic de, input logic hs,
                       input logic vs);
      @(negedge clk_in);
      clk_pixel = ck;
      data      = d;
      de_in     = de;
      hsync     = hs;
      vsync     = vs;
   endtask

   task automatic pixel(input logic [23:0] p, input logic de, input logic hs, input logic vs);
      slot(1'b1, p[11:0], de, hs, vs);
      slot(1'b0, p[23:12], de, hs, vs);
      if (de && !reset) begin
         exp_pix.push_back(p);
         exp_cyc.push_back(cyc + 3);
      end
   endtask

   task automatic line(input int w);
      logic [31:0] rnd;
      pixel(24'h0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < w; i++) begin
         rnd = $urandom;
         pixel(rnd[23:0], 1'b1, 1'b0, 1'b0);
      end
      pixel(24'h0, 1'b0, 1'b0, 1'b0);
      pixel(24'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic vpulse();
      pixel(24'h0, 1'b0, 1'b0, 1'b0);
      pixel(24'h0, 1'b0, 1'b0, 1'b1);
      pixel(24'h0, 1'b0, 1'b0, 1'b1);
      pixel(24'h0, 1'b0, 1'b0, 1'b0);
      pixel(24'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic frame(input int w, input int h, input int bad_line);
      for (int l = 0; l < h; l++) line((l == bad_line) ? w - 1 : w);
      vpulse();
   endtask

   // clk_pixel held high for two samples, then low with no preceding low half.
   task automatic glitch();
      slot(1'b1, 12'h0, 1'b0, 1'b0, 1'b0);
      slot(1'b1, 12'h0, 1'b0, 1'b0, 1'b0);
      slot(1'b0, 12'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_pixel_out"}, pixel_out, 32'd0);
      check_val({tag, "_pixel_valid"}, pixel_valid, 32'd0);
      check_val({tag, "_syncs"}, {de_out, hsync_out, vsync_out}, 32'd0);
      check_val({tag, "_h_active"}, h_active, 32'd0);
      check_val({tag, "_v_active"}, v_active, 32'd0);
      check_val({tag, "_locked"}, locked, 32'd0);
      check_val({tag, "_phase_err"}, phase_err, 32'd0);
      check_val({tag, "_err_count"}, err_count, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ph;
      repeat (4) pixel(24'h0, 1'b0, 1'b0, 1'b0);
      check_all_zero("reset");
      reset = 1'b0;
      repeat (3) pixel(24'h0, 1'b0, 1'b0, 1'b0);

      // Assembly: one DE pixel, one non-DE pixel.
      pixel(24'h123ABC, 1'b1, 1'b0, 1'b0);
      pixel(24'h456DEF, 1'b0, 1'b0, 1'b0);
      repeat (3) pixel(24'h0, 1'b0, 1'b0, 1'b0);
      check_val("valid_count", n_valid, 32'd1);

      // Arming edge, then lock on the third full frame.
      vpulse();
      check_val("arm_h_active", h_active, 32'd0);
      frame(16, 6, -1);
      frame(16, 6, -1);
      check_val("lock_after_2", locked, 32'd0);
      frame(16, 6, -1);
      check_val("lock_after_3", locked, 32'd1);
      check_val("h_active", h_active, 32'd16);
      check_val("v_active", v_active, 32'd6);
      check_val("err_initial", err_count, 32'd0);

      // Geometry change: one short line in the middle of a frame.
      frame(16, 6, 2);
      check_val("geom_unlock", locked, 32'd0);
      check_val("geom_err", err_count, 32'd1);
      frame(16, 6, -1);
      frame(16, 6, -1);
      check_val("geom_relock_2", locked, 32'd0);
      frame(16, 6, -1);
      check_val("geom_relock_3", locked, 32'd1);

      // Phase glitch while locked.
      ph = n_phase;
      glitch();
      pixel(24'h0, 1'b0, 1'b0, 1'b0);
      pixel(24'h0, 1'b0, 1'b0, 1'b0);
      check_val("glitch_phase_err", n_phase, ph + 1);
      check_val("glitch_unlock", locked, 32'd0);
      check_val("glitch_err", err_count, 32'd2);
      frame(16, 6, -1);
      frame(16, 6, -1);
      frame(16, 6, -1);
      check_val("glitch_relock", locked, 32'd1);

      // Reset in the middle of an active line.
      line(16);
      pixel(24'h0, 1'b0, 1'b1, 1'b0);
      pixel(24'hA5A5A5, 1'b1, 1'b0, 1'b0);
      pixel(24'h5A5A5A, 1'b1, 1'b0, 1'b0);
      #2 reset = 1'b1;
      exp_pix.delete();
      exp_cyc.delete();
      #1 check_all_zero("midreset");
      repeat (3) pixel(24'h0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      repeat (4) line(16);
      vpulse();
      check_val("partial_h_active", h_active, 32'd0);
      check_val("partial_locked", locked, 32'd0);
      frame(16, 6, -1);
      frame(16, 6, -1);
      check_val("rst_lock_after_2", locked, 32'd0);
      frame(16, 6, -1);
      check_val("rst_lock_after_3", locked, 32'd1);

      // Saturation: 300 lock losses by phase glitch, relocking each time.
      ph = n_phase;
      for (int i = 0; i < 300; i++) begin
         glitch();
         frame(2, 2, -1);
         frame(2, 2, -1);
         frame(2, 2, -1);
         if (i == 0) begin
            check_val("sat_first_err", err_count, 32'd1);
            check_val("sat_first_lock", locked, 32'd1);
            check_val("sat_first_h", h_active, 32'd2);
         end
      end
      check_val("sat_err", err_count, 32'd255);
      glitch();
      repeat (3) pixel(24'h0, 1'b0, 1'b0, 1'b0);
      check_val("sat_err_hold", err_count, 32'd255);
      check_val("sat_unlock", locked, 32'd0);
      check_val("sat_phase_cnt", n_phase, ph + 301);
      check_val("sb_empty", exp_pix.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/adv_ddr_rx.md
# adv_ddr_rx

Receive-side counterpart of the ADV7511 DDR video output path. Samples a 12-bit DDR pixel bus (low half while pixel clock high, high half while low), the forwarded pixel clock, DE, HSYNC and VSYNC. Rebuilds 24-bpp pixels, measures active width and height, and reports lock once the frame geometry is stable. Used as the loopback/checker endpoint on the video output and as capture front-end for external DDR video sources.

## Interface
Parameters:
- LOCK_FRAMES, 3, consecutive matching frames required to assert locked
- H_W, 12, width of horizontal active-pixel counter
- V_W, 11, width of vertical active-line counter

Ports:
- clk_in  in  1  sampling clock, exactly 2x pixel rate, edge-aligned with the DDR half-words
- reset  in  1  asynchronous, active-high; clears all state
- clk_pixel  in  1  forwarded pixel clock, sampled as data
- de_in  in  1  data enable from transmitter
- hsync, vsync  in  1 each  sync inputs
- data  in  12  DDR half-word bus
- pixel_out  out  24  assembled pixel {high, low}
- pixel_valid  out  1  one-cycle strobe per assembled pixel with DE
- de_out, hsync_out, vsync_out  out  1 each  syncs aligned to pixel_out
- h_active  out  H_W  last latched active pixels per line
- v_active  out  V_W  last latched active lines per frame
- locked  out  1  geometry stable
- phase_err  out  1  one-cycle strobe on clk_pixel phase violation
- err_count  out  8  saturating count of lock losses

## Operation
- Input stage: all inputs registered twice (s1, s2). All decoding uses s2.
- Phase decode:
  - s2.clk_pixel=1: capture data as low half, capture DE.
  - s2.clk_pixel=0 following a high sample: high half. Assemble {data, low}. Register pixel_out, de_out, hsync_out and vsync_out together. Pulse pixel_valid if captured DE=1.
- Phase check: two consecutive s2 samples with equal clk_pixel level -> phase_err pulse; half-word pairing restarts at the next high sample.
- Horizontal measure: count pixel_valid strobes while DE is high. On DE falling edge, latch the count into a line register and clear the counter. Saturate at 2^H_W-1.
- Within a frame, every DE line is compared against the frame's first line. Any difference sets frame_bad.
- Vertical measure: count DE falling edges. On vsync rising edge (s2):
  - latch h_active (first-line width) and v_active
  - clear the line counter and frame_bad
  - advance the FSM
- Lock FSM:
  - UNLOCKED: on vsync edge, load ref={h,v}, cnt=1, go CHECK.
  - CHECK: on vsync edge, if frame_bad=0 and measurement==ref then cnt++, else reload ref and set cnt=1. When cnt reaches LOCK_FRAMES, go LOCKED.
  - LOCKED: on vsync edge with mismatch or frame_bad, or on any phase_err: go UNLOCKED and err_count++ (saturates at 255).
- locked=1 only in LOCKED.
- Simultaneous phase_err and vsync edge in LOCKED: unlock once, increment err_count once.

## Timing
- Reset values:
  - pixel_out=0, pixel_valid=0, de_out=0, hsync_out=0, vsync_out=0
  - h_active=0, v_active=0, locked=0, phase_err=0, err_count=0
  - FSM=UNLOCKED, all counters 0
- Latency: high half on pins at cycle n (low half at n-1) -> pixel_out and pixel_valid at n+3.
- Syncs have the same 3-cycle latency as pixel data.
- h_active and v_active update 1 cycle after the s2 vsync rising edge. locked updates in the same cycle.
- phase_err is asserted 1 cycle after the offending s2 sample.
- Reset mid-frame: outputs drop asynchronously. Measurement restarts at the next vsync edge; the first partial frame is never latched.

## Structure
- Shared package: lock FSM state encoding (UNLOCKED, CHECK, LOCKED) and default H_W/V_W widths, shared with the video output path.
- One natural sub-module, adv_ddr_rx_measure: holds the H/V counters, frame_bad and the latch logic, and feeds compare results to the FSM in the top level.

## Test plan
- Reset: assert reset mid-stream -> every output 0 within the same cycle; locked stays 0 until LOCKED_FRAMES full frames after release.
- Assembly: low 0xABC, high 0x123 with DE=1 -> pixel_out=0x123ABC and pixel_valid pulse 3 cycles after the high half; DE=0 -> no pulse.
- Lock: three 1280x720 frames -> h_active=1280, v_active=720, locked=1 after the 3rd vsync edge. Two frames only -> locked=0.
- Geometry change: locked, then one frame with line 100 at 1279 pixels -> locked=0 at next vsync, err_count=1. Three further good frames -> relock.
- Phase glitch: hold clk_pixel high for 2 samples while locked -> phase_err pulse, locked=0, err_count increments; pairing resumes correctly on following pixels.
- Saturation: 300 forced lock losses -> err_count=255.
